// File: rtl/keypad_emulator.sv
// Emulates the far end of a 4x4 matrix keypad: queued key codes are "pressed"
// by pulling the key's row low whenever the scanner drives the key's column low.
module keypad_emulator #(
    parameter int HOLD_CYCLES = 1000,
    parameter int GAP_CYCLES  = 1000,
    parameter int DEPTH       = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              shift_col,
    output logic [3:0]              row,
    input  logic [3:0]              key_code,
    input  logic                    key_valid,
    output logic                    key_ready,
    output logic                    pressed,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [1:0]              fsm_state_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Handshake: a key transfers on a rising edge where key_valid && key_ready
    // and reset is low; key_ready depends only on the registered FIFO count.
    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    active_key_q, active_key_d;

    assign key_ready = (count_q != FULL_COUNT);
    assign push      = key_valid && key_ready && !reset;
    assign pop       = (state_q == IDLE) && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: a flush only has to clear pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= key_code;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        active_key_d = active_key_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    active_key_d = mem_q[rd_ptr_q];
                    timer_d      = HOLD_LOAD;
                    state_d      = PRESS;
                end
            end
            PRESS: begin
                if (timer_q == '0) begin
                    timer_d = GAP_LOAD;
                    state_d = GAP;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            GAP: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            active_key_q <= 4'h0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            active_key_q <= active_key_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    assign pressed     = (state_q == PRESS);
    assign busy        = (state_q != IDLE) || (count_q != '0);
    assign fifo_count  = count_q;
    assign fsm_state_o = state_q;

    // Physical-matrix rule: only the key's own column matters, any other
    // columns driven low at the same time leave the row untouched.
    always_comb begin
        row = 4'b1111;
        if (pressed && !shift_col[active_key_q[3:2]]) begin
            row[active_key_q[1:0]] = 1'b0;
        end
    end

endmodule
